// File: rtl/cache_pkg.sv
// Shared types and constants for the set-associative cache controller.
// Contents:
//   BYTE                       bits per byte
//   DEF_*                      default geometry (32-bit PA, 32-bit words, 16-word lines, 64 sets, 2 ways)
//   OFFSET_W/INDEX_W/TAG_W     address split for the default geometry
//   line_t                     one cache line of the default geometry
//   state_t                    controller state encoding
package cache_pkg;

    localparam int BYTE          = 8;
    localparam int DEF_PA_WIDTH  = 32;
    localparam int DEF_WRD_WIDTH = 32;
    localparam int DEF_BLK_WORDS = 16;
    localparam int DEF_SETS      = 64;
    localparam int DEF_WAYS      = 2;
    localparam int BLK_WIDTH     = DEF_BLK_WORDS * DEF_WRD_WIDTH;

    localparam int OFFSET_W = $clog2(BLK_WIDTH / BYTE);
    localparam int INDEX_W  = $clog2(DEF_SETS);
    localparam int TAG_W    = DEF_PA_WIDTH - INDEX_W - OFFSET_W;

    typedef logic [BLK_WIDTH-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        REFILL    = 3'd3,
        RESPOND   = 3'd4
    } state_t;

endpackage

// File: rtl/cache_way.sv
// One way of the cache: per-set valid, dirty, tag and line storage.
// Ports:
//   clk, rst_n            clock, async active-low reset (clears valid/dirty/tag)
//   idx                   set index used for read, install and word write
//   rd_valid/rd_dirty     state of the addressed entry
//   rd_tag/rd_line        tag and data of the addressed entry
//   inst_en/inst_tag/inst_line  install a full line (valid=1, dirty=0)
//   wr_en/wr_sel/wr_word  overwrite one word of the addressed line and mark it dirty
module cache_way
    import cache_pkg::*;
#(
    parameter int SETS      = 64,
    parameter int TAG_BITS  = 20,
    parameter int WRD_WIDTH = 32,
    parameter int BLK_WORDS = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [$clog2(SETS)-1:0]        idx,
    output logic                           rd_valid,
    output logic                           rd_dirty,
    output logic [TAG_BITS-1:0]            rd_tag,
    output logic [BLK_WORDS*WRD_WIDTH-1:0] rd_line,
    input  logic                           inst_en,
    input  logic [TAG_BITS-1:0]            inst_tag,
    input  logic [BLK_WORDS*WRD_WIDTH-1:0] inst_line,
    input  logic                           wr_en,
    input  logic [$clog2(BLK_WORDS)-1:0]   wr_sel,
    input  logic [WRD_WIDTH-1:0]           wr_word
);

    localparam int BLK_W = BLK_WORDS * WRD_WIDTH;

    logic [SETS-1:0]     valid_r;
    logic [SETS-1:0]     dirty_r;
    logic [TAG_BITS-1:0] tag_r  [SETS];
    logic [BLK_W-1:0]    data_r [SETS];

    assign rd_valid = valid_r[idx];
    assign rd_dirty = dirty_r[idx];
    assign rd_tag   = tag_r[idx];
    assign rd_line  = data_r[idx];

    // Entry bookkeeping: reset leaves every entry cold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {SETS{1'b0}};
            dirty_r <= {SETS{1'b0}};
            for (int s = 0; s < SETS; s++) begin
                tag_r[s] <= {TAG_BITS{1'b0}};
            end
        end else if (inst_en) begin
            valid_r[idx] <= 1'b1;
            dirty_r[idx] <= 1'b0;
            tag_r[idx]   <= inst_tag;
        end else if (wr_en) begin
            dirty_r[idx] <= 1'b1;
        end
    end

    // Line storage; contents are meaningless until the valid bit is set, so no reset.
    always_ff @(posedge clk) begin
        if (inst_en) begin
            data_r[idx] <= inst_line;
        end else if (wr_en) begin
            data_r[idx][wr_sel*WRD_WIDTH +: WRD_WIDTH] <= wr_word;
        end
    end

endmodule

// File: rtl/cache_assoc_ctrl.sv
// N-way set-associative, write-back, write-allocate cache controller.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             CPU request handshake (ready only in IDLE)
//   req_wr, addr, data_wr           request type, byte address, write data
//   resp_valid, hit, word_out       one-cycle completion pulse with hit flag and word
//   mem_addr, mem_rd_en, mem_wr_en  line-aligned memory transfer request
//   mem_wr_blk / mem_rd_blk         victim line out / refill line in
//   mem_ready                       memory completes the current transfer
module cache_assoc_ctrl
    import cache_pkg::*;
#(
    parameter int PA_WIDTH  = DEF_PA_WIDTH,
    parameter int WRD_WIDTH = DEF_WRD_WIDTH,
    parameter int BLK_WORDS = DEF_BLK_WORDS,
    parameter int SETS      = DEF_SETS,
    parameter int WAYS      = DEF_WAYS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_wr,
    input  logic [PA_WIDTH-1:0]            addr,
    input  logic [WRD_WIDTH-1:0]           data_wr,
    output logic                           resp_valid,
    output logic                           hit,
    output logic [WRD_WIDTH-1:0]           word_out,
    output logic [PA_WIDTH-1:0]            mem_addr,
    output logic                           mem_rd_en,
    output logic                           mem_wr_en,
    output logic [BLK_WORDS*WRD_WIDTH-1:0] mem_wr_blk,
    input  logic [BLK_WORDS*WRD_WIDTH-1:0] mem_rd_blk,
    input  logic                           mem_ready
);

    localparam int BLK_W    = BLK_WORDS * WRD_WIDTH;
    localparam int OFF_W    = $clog2(BLK_W / BYTE);
    localparam int BSEL_W   = $clog2(WRD_WIDTH / BYTE);
    localparam int WSEL_W   = $clog2(BLK_WORDS);
    localparam int IDX_W    = $clog2(SETS);
    localparam int TAG_BITS = PA_WIDTH - IDX_W - OFF_W;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t state_r, next_state_s;

    logic [TAG_BITS-1:0]  req_tag_r;
    logic [IDX_W-1:0]     req_idx_r;
    logic [WSEL_W-1:0]    req_wsel_r;
    logic                 req_wr_r;
    logic [WRD_WIDTH-1:0] req_data_r;
    logic [WAY_W-1:0]     sel_way_r;

    logic [WAYS-1:0]      way_valid_s, way_dirty_s, hit_vec_s, inst_en_s, wr_en_s;
    logic [TAG_BITS-1:0]  way_tag_s  [WAYS];
    logic [BLK_W-1:0]     way_line_s [WAYS];

    logic                 hit_any_s, inv_any_s, victim_dirty_s, evict_s, accept_s;
    logic [WAY_W-1:0]     hit_way_s, inv_way_s, victim_way_s, ptr_s;
    logic [BLK_W-1:0]     sel_line_s;
    logic [WRD_WIDTH-1:0] resp_word_s;
    logic                 unused_addr_s;

    logic                 req_ready_r, resp_valid_r, hit_r, mem_rd_en_r, mem_wr_en_r;
    logic [WRD_WIDTH-1:0] word_out_r;
    logic [PA_WIDTH-1:0]  mem_addr_r;
    logic [BLK_W-1:0]     mem_wr_blk_r;

    assign req_ready     = req_ready_r;
    assign resp_valid    = resp_valid_r;
    assign hit           = hit_r;
    assign word_out      = word_out_r;
    assign mem_addr      = mem_addr_r;
    assign mem_rd_en     = mem_rd_en_r;
    assign mem_wr_en     = mem_wr_en_r;
    assign mem_wr_blk    = mem_wr_blk_r;
    assign accept_s      = (state_r == IDLE) && req_valid;
    assign unused_addr_s = ^addr[BSEL_W-1:0];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way #(
            .SETS      (SETS),
            .TAG_BITS  (TAG_BITS),
            .WRD_WIDTH (WRD_WIDTH),
            .BLK_WORDS (BLK_WORDS)
        ) u_way (
            .clk       (clk),
            .rst_n     (rst_n),
            .idx       (req_idx_r),
            .rd_valid  (way_valid_s[w]),
            .rd_dirty  (way_dirty_s[w]),
            .rd_tag    (way_tag_s[w]),
            .rd_line   (way_line_s[w]),
            .inst_en   (inst_en_s[w]),
            .inst_tag  (req_tag_r),
            .inst_line (mem_rd_blk),
            .wr_en     (wr_en_s[w]),
            .wr_sel    (req_wsel_r),
            .wr_word   (req_data_r)
        );
    end

    // Round-robin pointer per set; only exists when there is a choice to make.
    if (WAYS > 1) begin : g_rr
        logic [WAY_W-1:0] rr_ptr_r [SETS];

        assign ptr_s = rr_ptr_r[req_idx_r];

        // Pointer advances only when a valid line is evicted; power-of-two WAYS wraps naturally.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < SETS; s++) begin
                    rr_ptr_r[s] <= {WAY_W{1'b0}};
                end
            end else if (evict_s) begin
                rr_ptr_r[req_idx_r] <= rr_ptr_r[req_idx_r] + {{(WAY_W-1){1'b0}}, 1'b1};
            end
        end
    end else begin : g_no_rr
        assign ptr_s = {WAY_W{1'b0}};
    end

    // Tag compare and victim choice; descending scans leave the lowest matching index.
    always_comb begin
        hit_vec_s = {WAYS{1'b0}};
        hit_way_s = {WAY_W{1'b0}};
        inv_way_s = {WAY_W{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec_s[w] = way_valid_s[w] && (way_tag_s[w] == req_tag_r);
            if (hit_vec_s[w]) begin
                hit_way_s = WAY_W'(w);
            end else begin
                hit_way_s = hit_way_s;
            end
            if (!way_valid_s[w]) begin
                inv_way_s = WAY_W'(w);
            end else begin
                inv_way_s = inv_way_s;
            end
        end
        hit_any_s = |hit_vec_s;
        inv_any_s = ~&way_valid_s;
        if (inv_any_s) begin
            victim_way_s = inv_way_s;
        end else begin
            victim_way_s = ptr_s;
        end
        victim_dirty_s = way_valid_s[victim_way_s] && way_dirty_s[victim_way_s];
        evict_s        = (state_r == LOOKUP) && !hit_any_s && !inv_any_s;
    end

    // Per-way install and word-write strobes, steered by the way chosen in LOOKUP.
    always_comb begin
        inst_en_s = {WAYS{1'b0}};
        wr_en_s   = {WAYS{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            inst_en_s[w] = (state_r == REFILL) && mem_ready && (sel_way_r == WAY_W'(w));
            wr_en_s[w]   = (state_r == RESPOND) && req_wr_r && (sel_way_r == WAY_W'(w));
        end
    end

    // Response word: a write returns the merged word, a read takes it from the hit line or the refill.
    always_comb begin
        if (state_r == LOOKUP) begin
            sel_line_s = way_line_s[hit_way_s];
        end else begin
            sel_line_s = mem_rd_blk;
        end
        if (req_wr_r) begin
            resp_word_s = req_data_r;
        end else begin
            resp_word_s = sel_line_s[req_wsel_r*WRD_WIDTH +: WRD_WIDTH];
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    next_state_s = LOOKUP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOOKUP: begin
                if (hit_any_s) begin
                    next_state_s = RESPOND;
                end else if (victim_dirty_s) begin
                    next_state_s = WRITEBACK;
                end else begin
                    next_state_s = REFILL;
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    next_state_s = REFILL;
                end else begin
                    next_state_s = WRITEBACK;
                end
            end
            REFILL: begin
                if (mem_ready) begin
                    next_state_s = RESPOND;
                end else begin
                    next_state_s = REFILL;
                end
            end
            RESPOND: next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture at accept, and the way this request will use once LOOKUP resolves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_tag_r  <= {TAG_BITS{1'b0}};
            req_idx_r  <= {IDX_W{1'b0}};
            req_wsel_r <= {WSEL_W{1'b0}};
            req_wr_r   <= 1'b0;
            req_data_r <= {WRD_WIDTH{1'b0}};
            sel_way_r  <= {WAY_W{1'b0}};
        end else begin
            if (accept_s) begin
                req_tag_r  <= addr[PA_WIDTH-1 -: TAG_BITS];
                req_idx_r  <= addr[OFF_W +: IDX_W];
                req_wsel_r <= addr[BSEL_W +: WSEL_W];
                req_wr_r   <= req_wr;
                req_data_r <= data_wr;
            end
            if (state_r == LOOKUP) begin
                sel_way_r <= hit_any_s ? hit_way_s : victim_way_s;
            end
        end
    end

    // Registered outputs, loaded from the state being entered so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            hit_r        <= 1'b0;
            word_out_r   <= {WRD_WIDTH{1'b0}};
            mem_rd_en_r  <= 1'b0;
            mem_wr_en_r  <= 1'b0;
            mem_addr_r   <= {PA_WIDTH{1'b0}};
            mem_wr_blk_r <= {BLK_W{1'b0}};
        end else begin
            req_ready_r  <= (next_state_s == IDLE);
            resp_valid_r <= (next_state_s == RESPOND);
            hit_r        <= (next_state_s == RESPOND) && (state_r == LOOKUP);
            mem_wr_en_r  <= (next_state_s == WRITEBACK);
            mem_rd_en_r  <= (next_state_s == REFILL);
            if (next_state_s == RESPOND) begin
                word_out_r <= resp_word_s;
            end
            if ((state_r == LOOKUP) && !hit_any_s) begin
                if (victim_dirty_s) begin
                    mem_addr_r   <= {way_tag_s[victim_way_s], req_idx_r, {OFF_W{1'b0}}};
                    mem_wr_blk_r <= way_line_s[victim_way_s];
                end else begin
                    mem_addr_r <= {req_tag_r, req_idx_r, {OFF_W{1'b0}}};
                end
            end else if ((state_r == WRITEBACK) && mem_ready) begin
                mem_addr_r <= {req_tag_r, req_idx_r, {OFF_W{1'b0}}};
            end
        end
    end

endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// Directed bench for cache_assoc_ctrl (2 ways, 64 sets) with a 3-cycle line memory.
module tb_cache_assoc_ctrl;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] data_wr = 32'h0;
    logic        resp_valid;
    logic        hit;
    logic [31:0] word_out;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    line_t       mem_wr_blk;
    line_t       mem_rd_blk = '0;
    logic        mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // memory model state
    line_t       mem_store [logic [31:0]];
    int          wait_cnt = 0;
    int          rd_count = 0;
    int          wr_count = 0;
    int          en_cycles = 0;
    int          both_cnt = 0;
    logic [31:0] last_rd_addr = 32'h0;
    logic [31:0] last_wr_addr = 32'hFFFF_FFFF;
    line_t       last_wr_blk = '0;

    cache_assoc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .addr       (addr),
        .data_wr    (data_wr),
        .resp_valid (resp_valid),
        .hit        (hit),
        .word_out   (word_out),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_blk (mem_wr_blk),
        .mem_rd_blk (mem_rd_blk),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line contents: previously written-back data, else word i = line address + 4*i.
    function automatic line_t make_line(input logic [31:0] a);
        line_t l;
        l = '0;
        if (mem_store.exists(a)) begin
            l = mem_store[a];
        end else begin
            for (int i = 0; i < 16; i++) l[32*i +: 32] = a + 32'(4 * i);
        end
        return l;
    endfunction

    // Memory completes each transfer on its third enabled cycle.
    always @(negedge clk) begin
        if (mem_rd_en || mem_wr_en) en_cycles++;
        if (mem_rd_en && mem_wr_en) both_cnt++;
        if (!rst_n) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end else if (mem_rd_en || mem_wr_en) begin
            wait_cnt++;
            if (wait_cnt == 3) begin
                mem_ready = 1'b1;
                if (mem_wr_en) begin
                    mem_store[mem_addr] = mem_wr_blk;
                    last_wr_addr = mem_addr;
                    last_wr_blk  = mem_wr_blk;
                    wr_count++;
                end else begin
                    mem_rd_blk   = make_line(mem_addr);
                    last_rd_addr = mem_addr;
                    rd_count++;
                end
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // One request: wait for ready, present it for one accept edge, count negedges to resp_valid.
    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic h, output logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("req_ready_wait", req_ready, 1'b1);
        req_valid = 1'b1;
        req_wr    = wr;
        addr      = a;
        data_wr   = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_val("resp_timeout", resp_valid, 1'b1);
        h = hit;
        w = word_out;
        @(negedge clk);
        check_val("resp_pulse", resp_valid, 1'b0);
        check_val("hit_idle", hit, 1'b0);
        check_val("word_hold", word_out, w);
    endtask

    initial begin
        int          lat, n, leak, rd0, wr0, en0;
        logic        h;
        logic [31:0] w;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_resp_valid", resp_valid, 1'b0);
        check_val("rst_hit", hit, 1'b0);
        check_val("rst_word_out", word_out, 32'h0);
        check_val("rst_mem_rd_en", mem_rd_en, 1'b0);
        check_val("rst_mem_wr_en", mem_wr_en, 1'b0);
        check_val("rst_mem_addr", mem_addr, 32'h0);
        check_val("rst_req_ready", req_ready, 1'b1);

        // 1: cold read miss, then hit
        rd0 = rd_count;
        do_req(1'b0, 32'h0000_0000, 32'h0, lat, h, w);
        check_val("t1_miss_hit", h, 1'b0);
        check_val("t1_miss_word", w, 32'h0000_0000);
        check_val("t1_miss_rds", rd_count - rd0, 1);
        check_val("t1_miss_rd_addr", last_rd_addr, 32'h0000_0000);
        check_val("t1_miss_lat", lat, 5);
        en0 = en_cycles;
        do_req(1'b0, 32'h0000_0000, 32'h0, lat, h, w);
        check_val("t1_hit_hit", h, 1'b1);
        check_val("t1_hit_lat", lat, 2);
        check_val("t1_hit_word", w, 32'h0000_0000);
        check_val("t1_hit_no_mem", en_cycles - en0, 0);

        // 2: write hit, read back
        en0 = en_cycles;
        do_req(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, lat, h, w);
        check_val("t2_wr_hit", h, 1'b1);
        check_val("t2_wr_word", w, 32'hDEAD_BEEF);
        check_val("t2_wr_lat", lat, 2);
        do_req(1'b0, 32'h0000_0004, 32'h0, lat, h, w);
        check_val("t2_rd_hit", h, 1'b1);
        check_val("t2_rd_word", w, 32'hDEAD_BEEF);
        check_val("t2_no_mem", en_cycles - en0, 0);

        // 3: fill way 1, then evict dirty way 0
        do_req(1'b0, 32'h0000_1000, 32'h0, lat, h, w);
        check_val("t3a_hit", h, 1'b0);
        check_val("t3a_word", w, 32'h0000_1000);
        wr0 = wr_count;
        do_req(1'b0, 32'h0000_2000, 32'h0, lat, h, w);
        check_val("t3b_hit", h, 1'b0);
        check_val("t3b_wbs", wr_count - wr0, 1);
        check_val("t3b_wb_addr", last_wr_addr, 32'h0000_0000);
        check_val("t3b_wb_word1", last_wr_blk[63:32], 32'hDEAD_BEEF);
        check_val("t3b_wb_word0", last_wr_blk[31:0], 32'h0000_0000);
        check_val("t3b_rd_addr", last_rd_addr, 32'h0000_2000);
        check_val("t3b_word", w, 32'h0000_2000);
        check_val("t3b_lat", lat, 9);

        // 4: clean victim (0x1000 line), data comes back from memory
        wr0 = wr_count;
        do_req(1'b0, 32'h0000_0004, 32'h0, lat, h, w);
        check_val("t4_hit", h, 1'b0);
        check_val("t4_no_wb", wr_count - wr0, 0);
        check_val("t4_word", w, 32'hDEAD_BEEF);
        check_val("t4_lat", lat, 5);

        // 5: reset during refill
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        addr      = 32'h0000_3000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_rd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("t5_rd_en_seen", mem_rd_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("t5_rd_en_drop", mem_rd_en, 1'b0);
        check_val("t5_resp_drop", resp_valid, 1'b0);
        check_val("t5_addr_clr", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd0 = rd_count;
        do_req(1'b0, 32'h0000_0000, 32'h0, lat, h, w);
        check_val("t5_cold_hit", h, 1'b0);
        check_val("t5_cold_rds", rd_count - rd0, 1);
        check_val("t5_cold_word", w, 32'h0000_0000);

        // 6: req_valid held through a miss; next request taken the cycle after resp_valid
        rd0 = rd_count;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        addr      = 32'h0000_0040;
        @(posedge clk);
        #1;
        addr = 32'h0000_0044;
        leak = 0;
        n = 0;
        while (!resp_valid && n < 200) begin
            @(negedge clk);
            n++;
            if (req_ready) leak++;
        end
        check_val("t6a_resp_timeout", resp_valid, 1'b1);
        check_val("t6a_hit", hit, 1'b0);
        check_val("t6a_word", word_out, 32'h0000_0040);
        check_val("t6a_ready_low", leak, 0);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (resp_valid) break;
        end
        req_valid = 1'b0;
        check_val("t6b_gap", n, 3);
        check_val("t6b_hit", hit, 1'b1);
        check_val("t6b_word", word_out, 32'h0000_0044);
        check_val("t6_rds", rd_count - rd0, 1);

        repeat (2) @(negedge clk);
        check_val("mem_en_exclusive", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
